// File: rtl/aes_round_scheduler_pkg.sv
// rtl/aes_round_scheduler_pkg.sv - shared types and helpers for the AES round scheduler
// Package aes_sched_pkg: key-size encodings, scheduler state enum and the
// key-size to round-count (Nr) lookup used by the scheduler top.
package aes_sched_pkg;

   localparam logic [1:0] KSIZE_128 = 2'b00;
   localparam logic [1:0] KSIZE_192 = 2'b01;
   localparam logic [1:0] KSIZE_256 = 2'b10;
   localparam logic [1:0] KSIZE_BAD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_ROUND = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Nr of 0 marks an illegal key size; the scheduler skips the datapath for it.
   function automatic logic [3:0] nr_of(input logic [1:0] ksize);
      case (ksize)
         KSIZE_128: nr_of = 4'd10;
         KSIZE_192: nr_of = 4'd12;
         KSIZE_256: nr_of = 4'd14;
         default:   nr_of = 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/aes_round_scheduler_if.sv
// rtl/aes_round_scheduler_if.sv - request, datapath and response signals of the scheduler
// Parameter NUM_REQ: number of requesters (1..4).
// Groups: req_* (per-requester job requests), dp_* (round datapath control and
// returned state), rsp_* (result handshake).
// Modports: slave = scheduler side, master = requesters/datapath/consumer side.
interface aes_round_scheduler_if #(
   parameter int NUM_REQ = 2
);
   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ-1:0]     req_ready;
   logic [NUM_REQ-1:0]     req_decrypt;
   logic [2*NUM_REQ-1:0]   req_ksize;
   logic [128*NUM_REQ-1:0] req_block;

   logic [127:0] dp_block;
   logic         dp_load;
   logic         dp_step;
   logic         dp_last;
   logic [3:0]   dp_key_idx;
   logic         dp_decrypt;
   logic [1:0]   dp_ksize;
   logic [1:0]   dp_key_sel;
   logic [127:0] dp_state;

   logic         rsp_valid;
   logic         rsp_ready;
   logic [127:0] rsp_block;
   logic [1:0]   rsp_id;
   logic         rsp_error;

   modport slave (
      input  req_valid, req_decrypt, req_ksize, req_block, dp_state, rsp_ready,
      output req_ready, dp_block, dp_load, dp_step, dp_last, dp_key_idx,
             dp_decrypt, dp_ksize, dp_key_sel, rsp_valid, rsp_block, rsp_id, rsp_error
   );

   modport master (
      output req_valid, req_decrypt, req_ksize, req_block, dp_state, rsp_ready,
      input  req_ready, dp_block, dp_load, dp_step, dp_last, dp_key_idx,
             dp_decrypt, dp_ksize, dp_key_sel, rsp_valid, rsp_block, rsp_id, rsp_error
   );

endinterface

// File: rtl/aes_round_scheduler_arbiter.sv
// rtl/aes_round_scheduler_arbiter.sv - round-robin requester selection
// Module aes_rr_arbiter. Ports: req (request vector), last (id of the previous
// grant), gnt (one-hot grant), id (granted index), any (some request present).
// Search starts at the requester after last and wraps around.
module aes_rr_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [1:0]         last,
   output logic [NUM_REQ-1:0] gnt,
   output logic [1:0]         id,
   output logic               any
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [IW-1:0] idx;

   always_comb begin
      gnt = '0;
      id  = last;
      any = 1'b0;
      idx = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = IW'((int'(last) + i) % NUM_REQ);
         if (!any && req[idx]) begin
            gnt[idx] = 1'b1;
            id       = 2'(idx);
            any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/aes_round_scheduler.sv
// rtl/aes_round_scheduler.sv - schedules AES jobs from several requesters onto one round datapath
// Ports: clk, rst (synchronous, active-high), bus (aes_round_scheduler_if.slave:
// req_*, dp_*, rsp_*), perf_busy (busy-cycle counter), perf_jobs (response count).
// One job at a time: IDLE -> LOAD -> ROUND x Nr -> DONE, or IDLE -> DONE with
// rsp_error for an illegal key size.
// Optional macro AES_SCHED_PERF_EN builds the performance counters; otherwise
// they read as zero.
module aes_round_scheduler
   import aes_sched_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   aes_round_scheduler_if.slave       bus,
   output logic [31:0]                perf_busy,
   output logic [15:0]                perf_jobs
);
   state_t state, state_nx;

   logic [3:0]   rnd, nr;
   logic [1:0]   last_ptr, job_id, job_ksize;
   logic         job_dec, rsp_error_q;
   logic [127:0] job_block, rsp_block_q;

   logic [NUM_REQ-1:0] gnt;
   logic [1:0]         gnt_id;
   logic               gnt_any, accept;
   logic               sel_dec;
   logic [1:0]         sel_ksize;
   logic [127:0]       sel_block;

   aes_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req  (bus.req_valid),
      .last (last_ptr),
      .gnt  (gnt),
      .id   (gnt_id),
      .any  (gnt_any)
   );

   assign accept = (state == ST_IDLE) && gnt_any && !rst;

   // Mux the granted requester's job fields with constant slices.
   always_comb begin
      sel_dec   = 1'b0;
      sel_ksize = '0;
      sel_block = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_id == 2'(i)) begin
            sel_dec   = bus.req_decrypt[i];
            sel_ksize = bus.req_ksize[2*i +: 2];
            sel_block = bus.req_block[128*i +: 128];
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (accept) state_nx = (nr_of(sel_ksize) == 4'd0) ? ST_DONE : ST_LOAD;
         ST_LOAD:  state_nx = ST_ROUND;
         ST_ROUND: if (rnd == nr) state_nx = ST_DONE;
         ST_DONE:  if (bus.rsp_ready) state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         rnd         <= '0;
         nr          <= '0;
         last_ptr    <= 2'(NUM_REQ - 1);
         job_id      <= '0;
         job_dec     <= 1'b0;
         job_ksize   <= '0;
         job_block   <= '0;
         rsp_block_q <= '0;
         rsp_error_q <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  last_ptr  <= gnt_id;
                  job_id    <= gnt_id;
                  job_dec   <= sel_dec;
                  job_ksize <= sel_ksize;
                  job_block <= sel_block;
                  nr        <= nr_of(sel_ksize);
                  rnd       <= '0;
                  if (nr_of(sel_ksize) == 4'd0) begin
                     rsp_block_q <= '0;
                     rsp_error_q <= 1'b1;
                  end
               end
            end
            ST_LOAD: rnd <= 4'd1;
            ST_ROUND: begin
               if (rnd == nr) begin
                  rsp_block_q <= bus.dp_state;
                  rsp_error_q <= 1'b0;
                  rnd         <= '0;
               end else begin
                  rnd <= rnd + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready  = accept ? gnt : '0;
   assign bus.dp_load    = (state == ST_LOAD);
   assign bus.dp_step    = (state == ST_ROUND);
   assign bus.dp_last    = (state == ST_ROUND) && (rnd == nr);
   // Decrypt walks the key schedule backwards: Nr at load, Nr-r in round r.
   assign bus.dp_key_idx = (state == ST_LOAD)  ? (job_dec ? nr : 4'd0) :
                           (state == ST_ROUND) ? (job_dec ? nr - rnd : rnd) : 4'd0;
   assign bus.dp_block   = job_block;
   assign bus.dp_decrypt = job_dec;
   assign bus.dp_ksize   = job_ksize;
   assign bus.dp_key_sel = job_id;
   assign bus.rsp_valid  = (state == ST_DONE);
   assign bus.rsp_block  = rsp_block_q;
   assign bus.rsp_id     = job_id;
   assign bus.rsp_error  = rsp_error_q;

`ifdef AES_SCHED_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_busy <= '0;
         perf_jobs <= '0;
      end else begin
         if (state != ST_IDLE && perf_busy != '1) perf_busy <= perf_busy + 32'd1;
         if (bus.rsp_valid && bus.rsp_ready)      perf_jobs <= perf_jobs + 16'd1;
      end
   end
`else
   assign perf_busy = '0;
   assign perf_jobs = '0;
`endif

endmodule

// File: tb/tb_aes_round_scheduler.sv
// tb/tb_aes_round_scheduler.sv - directed self-checking bench for aes_round_scheduler
module tb_aes_round_scheduler;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] perf_busy;
   logic [15:0] perf_jobs;

   aes_round_scheduler_if #(.NUM_REQ(2)) bus ();

   aes_round_scheduler #(.NUM_REQ(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .perf_busy (perf_busy),
      .perf_jobs (perf_jobs)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nfail = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int id, input bit dec, input logic [1:0] ks, input logic [127:0] blk);
      bus.req_decrypt[id]        = dec;
      bus.req_ksize[2*id +: 2]   = ks;
      bus.req_block[128*id +: 128] = blk;
   endtask

   // One job: grant check, cycle-by-cycle datapath checks, optional response stall.
   task automatic run_job(input string tag, input int id, input bit dec, input logic [1:0] ks,
                          input logic [127:0] blk, input int exp_lat, input bit exp_err, input int stall);
      int nr, loads, steps, lat;
      logic [127:0] last_state, rb;
      logic [1:0] eg, rid;
      nr = (ks == 2'b00) ? 10 : (ks == 2'b01) ? 12 : (ks == 2'b10) ? 14 : 0;
      loads = 0; steps = 0; lat = 0; last_state = '0;
      eg = '0; eg[id] = 1'b1;
      set_req(id, dec, ks, blk);
      bus.req_valid = '0;
      bus.req_valid[id] = 1'b1;
      #1;
      chk({tag, " grant"}, 128'(bus.req_ready), 128'(eg));
      tick;
      // Disturb every request input while the job runs.
      bus.req_valid   = '1;
      bus.req_block   = ~bus.req_block;
      bus.req_ksize   = ~bus.req_ksize;
      bus.req_decrypt = ~bus.req_decrypt;
      #1;
      for (int c = 1; c <= 40; c++) begin
         if (bus.rsp_valid) begin
            lat = c;
            break;
         end
         chk({tag, " ready busy"}, 128'(bus.req_ready), 128'(0));
         if (bus.dp_load) begin
            loads++;
            chk({tag, " load idx"}, 128'(bus.dp_key_idx), 128'(dec ? nr : 0));
            chk({tag, " load blk"}, bus.dp_block, blk);
            chk({tag, " load mode"}, 128'({bus.dp_decrypt, bus.dp_ksize, bus.dp_key_sel}),
                128'({dec, ks, 2'(id)}));
         end
         if (bus.dp_step) begin
            steps++;
            chk({tag, " step idx"}, 128'(bus.dp_key_idx), 128'(dec ? nr - steps : steps));
            chk({tag, " step last"}, 128'(bus.dp_last), 128'(steps == nr));
            chk({tag, " step blk"}, bus.dp_block, blk);
         end
         bus.dp_state = blk + 128'(c * 7);
         if (bus.dp_last) last_state = bus.dp_state;
         tick;
      end
      bus.req_valid = '0;
      chk({tag, " loads"}, 128'(loads), 128'(nr == 0 ? 0 : 1));
      chk({tag, " steps"}, 128'(steps), 128'(nr));
      chk({tag, " latency"}, 128'(lat), 128'(exp_lat));
      chk({tag, " rsp_block"}, bus.rsp_block, last_state);
      chk({tag, " rsp_error"}, 128'(bus.rsp_error), 128'(exp_err));
      chk({tag, " rsp_id"}, 128'(bus.rsp_id), 128'(id));
      rb = bus.rsp_block;
      rid = bus.rsp_id;
      bus.req_valid = '1;
      bus.rsp_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
         tick;
         chk({tag, " stall valid"}, 128'(bus.rsp_valid), 128'(1));
         chk({tag, " stall blk"}, bus.rsp_block, rb);
         chk({tag, " stall id"}, 128'({bus.rsp_error, bus.rsp_id}), 128'({exp_err, rid}));
         chk({tag, " stall ready"}, 128'(bus.req_ready), 128'(0));
      end
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      tick;
      bus.rsp_ready = 1'b0;
      #1;
      chk({tag, " rsp cleared"}, 128'(bus.rsp_valid), 128'(0));
   endtask

   initial begin
      int g, nrsp, steps_seen, rsp_seen;
      rst = 1'b1;
      bus.req_valid = '0; bus.req_decrypt = '0; bus.req_ksize = '0; bus.req_block = '0;
      bus.dp_state = '0; bus.rsp_ready = 1'b0;
      tick; tick;
      rst = 1'b0;
      #1;
      chk("reset rsp_valid", 128'(bus.rsp_valid), 128'(0));
      chk("reset dp ctl", 128'({bus.dp_load, bus.dp_step, bus.dp_last, bus.dp_key_idx}), 128'(0));
      chk("reset dp_block", bus.dp_block, 128'(0));
      chk("reset rsp_block", bus.rsp_block, 128'(0));
      chk("reset ready", 128'(bus.req_ready), 128'(0));

      run_job("enc128", 0, 1'b0, 2'b00, 128'h00112233445566778899aabbccddeeff, 12, 1'b0, 0);
      run_job("dec256", 1, 1'b1, 2'b10, 128'hdeadbeef0123456789abcdeffedcba98, 16, 1'b0, 0);
      run_job("illegal", 1, 1'b0, 2'b11, 128'h5555aaaa5555aaaa5555aaaa5555aaaa, 1, 1'b1, 0);
      run_job("stall192", 1, 1'b0, 2'b01, 128'h0f0e0d0c0b0a09080706050403020100, 14, 1'b0, 5);

      // Both requesters always valid: grants must alternate 0,1,0,1.
      set_req(0, 1'b0, 2'b00, 128'h1111);
      set_req(1, 1'b0, 2'b00, 128'h2222);
      bus.req_valid = 2'b11;
      bus.rsp_ready = 1'b1;
      g = 0; nrsp = 0;
      #1;
      for (int c = 0; c < 200 && g < 4; c++) begin
         if (bus.req_ready != 2'b00) begin
            chk("rr grant", 128'(bus.req_ready), 128'((g % 2 == 0) ? 2'b01 : 2'b10));
            g++;
         end
         if (bus.rsp_valid) begin
            chk("rr rsp_id", 128'(bus.rsp_id), 128'(nrsp % 2));
            nrsp++;
         end
         tick;
      end
      bus.req_valid = '0;
      chk("rr grants", 128'(g), 128'(4));
      for (int c = 0; c < 30; c++) begin
         if (bus.rsp_valid) begin
            chk("rr last rsp_id", 128'(bus.rsp_id), 128'(1));
            tick;
            break;
         end
         tick;
      end
      bus.rsp_ready = 1'b0;

      // Reset in the middle of round 5.
      set_req(1, 1'b0, 2'b00, 128'h77);
      bus.req_valid = 2'b10;
      #1;
      chk("rst job grant", 128'(bus.req_ready), 128'(2'b10));
      tick;
      bus.req_valid = '0;
      for (int c = 0; c < 20; c++) begin
         if (bus.dp_step && bus.dp_key_idx == 4'd5) break;
         tick;
      end
      chk("rst at r5", 128'({bus.dp_step, bus.dp_key_idx}), 128'({1'b1, 4'd5}));
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("rst dp ctl", 128'({bus.dp_load, bus.dp_step, bus.dp_last, bus.dp_key_idx}), 128'(0));
      chk("rst dp job", 128'({bus.dp_decrypt, bus.dp_ksize, bus.dp_key_sel}), 128'(0));
      chk("rst dp_block", bus.dp_block, 128'(0));
      chk("rst rsp", 128'({bus.rsp_valid, bus.rsp_id, bus.rsp_error}), 128'(0));
      chk("rst rsp_block", bus.rsp_block, 128'(0));
      steps_seen = 0; rsp_seen = 0;
      for (int c = 0; c < 20; c++) begin
         tick;
         if (bus.dp_step) steps_seen++;
         if (bus.rsp_valid) rsp_seen++;
      end
      chk("rst no step", 128'(steps_seen), 128'(0));
      chk("rst no rsp", 128'(rsp_seen), 128'(0));
      bus.req_valid = 2'b11;
      #1;
      chk("rst first grant", 128'(bus.req_ready), 128'(2'b01));
      bus.req_valid = '0;
`ifndef AES_SCHED_PERF_EN
      chk("perf off", 128'({perf_busy, perf_jobs}), 128'(0));
`endif
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/aes_round_scheduler.md
AES_ROUND_SCHEDULER -- requirements
Module: aes_round_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 2: number of requesters, legal range 1..4.
REQ-002 Port clk  in  1: single clock; every register updates on its rising edge.
REQ-003 Port rst  in  1: reset, synchronous and active-high.
REQ-004 Port req_valid  in  NUM_REQ: per-requester job request.
REQ-005 Port req_ready  out  NUM_REQ: per-requester accept; a job transfers when valid and ready are both high.
REQ-006 Port req_decrypt  in  NUM_REQ: 1 = decrypt job, 0 = encrypt job.
REQ-007 Port req_ksize  in  2*NUM_REQ: key size per requester; 00 = 128, 01 = 192, 10 = 256, 11 = illegal.
REQ-008 Port req_block  in  128*NUM_REQ: input block per requester.
REQ-009 Port dp_block  out  128: block presented to the round datapath.
REQ-010 Port dp_load  out  1: datapath loads dp_block and applies round key 0.
REQ-011 Port dp_step  out  1: datapath executes one round.
REQ-012 Port dp_last  out  1: current round is the final round (no MixColumns).
REQ-013 Port dp_key_idx  out  4: round-key index.
REQ-014 Port dp_decrypt  out  1, dp_ksize  out  2, dp_key_sel  out  2: mode, key size and key-bank select (granted id).
REQ-015 Port dp_state  in  128: datapath state register after the current operation.
REQ-016 Port rsp_valid  out  1, rsp_ready  in  1: response handshake.
REQ-017 Port rsp_block  out  128, rsp_id  out  2, rsp_error  out  1: result, originating requester, illegal-ksize flag.
REQ-018 Ports perf_busy  out  32 and perf_jobs  out  16: performance counters (see Configuration).

Function
REQ-019 FSM states IDLE, LOAD, ROUND, DONE; exactly one job outstanding.
REQ-020 In IDLE with any req_valid high, grant the requester chosen round-robin, starting from the requester after the last grant; req_ready is high only for that requester and only in that cycle.
REQ-021 req_ready is 0 in every state except IDLE.
REQ-022 The accepted id, decrypt bit, ksize and block are captured at the handshake.
REQ-023 Nr = 10/12/14 for ksize 00/01/10.
REQ-024 Legal ksize: IDLE -> LOAD (dp_load = 1 for 1 cycle, dp_key_idx = 0 for encrypt, Nr for decrypt) -> ROUND for Nr cycles.
REQ-025 In ROUND, the round counter r = 1..Nr, dp_step = 1, dp_key_idx = r for encrypt or Nr-r for decrypt, and dp_last = 1 only when r == Nr.
REQ-026 At the end of the final ROUND cycle, capture dp_state into rsp_block, set rsp_error = 0 and go to DONE.
REQ-027 Latency: handshake in cycle 0 gives rsp_valid high from cycle Nr+2 (12/14/16).
REQ-028 Illegal ksize: IDLE -> DONE directly, with rsp_error = 1, rsp_block = 0, rsp_valid high from cycle 1, and no dp_load or dp_step.
REQ-029 In DONE, rsp_valid = 1 and rsp_block, rsp_id and rsp_error hold stable until rsp_ready; on the handshake go to IDLE, with the next grant no earlier than the following cycle.
REQ-030 dp_decrypt, dp_ksize, dp_key_sel and dp_block hold the captured job values from LOAD through the last ROUND cycle.
REQ-031 dp_load, dp_step and dp_last are 0 outside LOAD and ROUND.
REQ-032 Changes on req_* inputs during a job have no effect on that job.

Reset
REQ-033 rst forces IDLE, round counter 0 and the round-robin pointer to NUM_REQ-1 (requester 0 first).
REQ-034 rst clears all outputs to 0.
REQ-035 rst mid-job drops the job with no response and no further dp_step.

Configuration
REQ-036 With AES_SCHED_PERF_EN defined:
- perf_busy increments each cycle the state is not IDLE, saturating at all-ones.
- perf_jobs increments on each response handshake, wrapping.
- Both counters clear on rst.
REQ-037 Without AES_SCHED_PERF_EN, perf_busy and perf_jobs are tied to 0 and no counter logic is built.

Structure
REQ-038 Package aes_sched_pkg holds the ksize encoding constants, the state enum and an Nr lookup function (ksize -> Nr).
REQ-039 Round-robin selection is the sub-module aes_rr_arbiter (inputs req vector and last-grant pointer; outputs one-hot grant and id).

Verification
REQ-040 Single encrypt, requester 0, ksize 00, block 0x00112233445566778899aabbccddeeff: exactly 1 dp_load, 10 dp_step, dp_last on step 10; rsp_valid at cycle 12, rsp_id = 0.
REQ-041 Decrypt with ksize 10: dp_key_idx sequence 14, 13, ..., 0; rsp_valid at cycle 16.
REQ-042 Both requesters valid continuously, rsp_ready = 1: grants alternate 0, 1, 0, 1 with no starvation.
REQ-043 ksize 11 from requester 1: no dp_load or dp_step, rsp_error = 1, rsp_block = 0 at cycle 1.
REQ-044 rsp_ready low for 5 cycles in DONE: response stable and req_ready stays 0.
REQ-045 rst asserted at ROUND r = 5: next cycle IDLE with all outputs 0, no response, and requester 0 granted first afterwards.
